// File: rtl/instr_fetch_unit.sv
// PC/fetch stage: presents pc to a combinational imem, registers {instr, pc} toward decode over valid/ready.
// Latency 1 clk pc->out_*, 1 instr/cycle; stalls hold pc and out_* while out_valid&&!out_ready. Optional macro FETCH_JMP_PREDECODE_EN.
module instr_fetch_unit #(
    parameter int                 ADDR_W    = 32,
    parameter int                 MEM_DEPTH = 11,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [5:0]         HALT_OP   = 6'h3F
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_DEPTH - 1);
`ifdef FETCH_JMP_PREDECODE_EN
    localparam logic [5:0] JMP_OP = 6'h02;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              halted_q, halted_d;

    logic              load;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] pc_inc;

    assign load   = !out_valid_q || out_ready;
    assign opcode = imem_instr[31:26];
    // Wrap applies only here; redirect and jump targets are taken verbatim.
    assign pc_inc = (pc_q == LAST_PC) ? '0 : pc_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        halted_d    = halted_q;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (load) begin
`ifdef FETCH_JMP_PREDECODE_EN
                    if (opcode == JMP_OP) begin
                        pc_d        = ADDR_W'(imem_instr[24:0]);
                        out_valid_d = 1'b0;
                    end else
`endif
                    begin
                        out_instr_d = imem_instr;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        if (opcode == HALT_OP) begin
                            state_d  = ST_HALTED;
                            halted_d = 1'b1;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                end
            end
            ST_HALTED: begin
                halted_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Redirect overrides everything after the boot bubble, including a stalled output.
        if (redirect_valid && (state_q != ST_BOOT)) begin
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
            state_d     = ST_RUN;
            halted_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            halted_q    <= halted_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, stall, wrap, redirect, halt, jump opcode, reset behaviour.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    int total;
    int bad;

    logic [31:0] mem [0:15];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    assign imem_instr = (imem_addr < 32'd16) ? mem[imem_addr[3:0]] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", out_instr); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", out_pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
        step();
        step();
    endtask

    // Release reset and stream words 0..2; leaves out_pc=2 presented.
    task automatic test_boot_stream();
        rst_n = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL boot_bubble got=%b want=0", out_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL boot_addr got=%h want=0", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=1", i, out_valid); end
            total++; if (out_pc !== 32'(i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, out_pc, i); end
            total++; if (out_instr !== 32'h20010005 + 32'(i)) begin bad++; $display("FAIL stream_instr[%0d] got=%h want=%h", i, out_instr, 32'h20010005 + 32'(i)); end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (out_pc !== 32'd2) begin bad++; $display("FAIL stall_pc[%0d] got=%h want=2", i, out_pc); end
            total++; if (out_instr !== 32'h20010007) begin bad++; $display("FAIL stall_instr[%0d] got=%h want=20010007", i, out_instr); end
            total++; if (imem_addr !== 32'd3) begin bad++; $display("FAIL stall_addr[%0d] got=%h want=3", i, imem_addr); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b want=1", i, out_valid); end
        end
        out_ready = 1'b1;
        step();
        total++; if (out_pc !== 32'd3) begin bad++; $display("FAIL stall_release_pc got=%h want=3", out_pc); end
    endtask

    // From out_pc=3, run on to wrap past MEM_DEPTH-1=10.
    task automatic test_wrap();
        for (int i = 4; i <= 8; i++) step();
        total++; if (out_pc !== 32'd8) begin bad++; $display("FAIL wrap_pre got=%h want=8", out_pc); end
        step();
        total++; if (out_pc !== 32'd9) begin bad++; $display("FAIL wrap_9 got=%h want=9", out_pc); end
        step();
        total++; if (out_pc !== 32'd10) begin bad++; $display("FAIL wrap_10 got=%h want=a", out_pc); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL wrap_addr got=%h want=0", imem_addr); end
        step();
        total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL wrap_0 got=%h want=0", out_pc); end
        step();
        total++; if (out_pc !== 32'd1) begin bad++; $display("FAIL wrap_1 got=%h want=1", out_pc); end
    endtask

    task automatic test_redirect_stalled();
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'd7;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b want=0", out_valid); end
        total++; if (imem_addr !== 32'd7) begin bad++; $display("FAIL redir_addr got=%h want=7", imem_addr); end
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL redir_valid got=%b want=1", out_valid); end
        total++; if (out_pc !== 32'd7) begin bad++; $display("FAIL redir_pc got=%h want=7", out_pc); end
        total++; if (out_instr !== 32'h2001000C) begin bad++; $display("FAIL redir_instr got=%h want=2001000c", out_instr); end
    endtask

    task automatic test_halt();
        mem[4] = 32'hFC000000;
        redirect_valid = 1'b1;
        redirect_pc = 32'd3;
        step();
        redirect_valid = 1'b0;
        step();
        total++; if (out_pc !== 32'd3) begin bad++; $display("FAIL halt_pre got=%h want=3", out_pc); end
        step();
        total++; if (out_pc !== 32'd4) begin bad++; $display("FAIL halt_pc got=%h want=4", out_pc); end
        total++; if (out_instr !== 32'hFC000000) begin bad++; $display("FAIL halt_instr got=%h want=fc000000", out_instr); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL halt_valid got=%b want=1", out_valid); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b want=1", halted); end
        total++; if (imem_addr !== 32'd4) begin bad++; $display("FAIL halt_addr got=%h want=4", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL halted_valid[%0d] got=%b want=0", i, out_valid); end
            total++; if (imem_addr !== 32'd4) begin bad++; $display("FAIL halted_addr[%0d] got=%h want=4", i, imem_addr); end
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        step();
        redirect_valid = 1'b0;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL unhalt_flag got=%b want=0", halted); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL unhalt_addr got=%h want=0", imem_addr); end
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL resume_valid got=%b want=1", out_valid); end
        total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL resume_pc got=%h want=0", out_pc); end
        mem[4] = 32'h20010009;
    endtask

    task automatic test_jmp();
        mem[1] = 32'h08000006;
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        step();
        redirect_valid = 1'b0;
        step();
        total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL jmp_pc0 got=%h want=0", out_pc); end
        step();
`ifdef FETCH_JMP_PREDECODE_EN
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL jmp_bubble got=%b want=0", out_valid); end
        total++; if (imem_addr !== 32'd6) begin bad++; $display("FAIL jmp_target got=%h want=6", imem_addr); end
        step();
        total++; if (out_pc !== 32'd6) begin bad++; $display("FAIL jmp_pc6 got=%h want=6", out_pc); end
        step();
        total++; if (out_pc !== 32'd7) begin bad++; $display("FAIL jmp_pc7 got=%h want=7", out_pc); end
`else
        total++; if (out_pc !== 32'd1) begin bad++; $display("FAIL jmp_pc1 got=%h want=1", out_pc); end
        total++; if (out_instr !== 32'h08000006) begin bad++; $display("FAIL jmp_word got=%h want=08000006", out_instr); end
        step();
        total++; if (out_pc !== 32'd2) begin bad++; $display("FAIL jmp_pc2 got=%h want=2", out_pc); end
`endif
        mem[1] = 32'h20010006;
    endtask

    // Mid-stream async reset, then a redirect held through the boot bubble must be ignored.
    task automatic test_reset_midrun();
        step();
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", out_valid); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL async_addr got=%h want=0", imem_addr); end
        total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL async_pc got=%h want=0", out_pc); end
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'd5;
        rst_n = 1'b1;
        step();
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL boot_redir_addr got=%h want=0", imem_addr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL boot_redir_valid got=%b want=0", out_valid); end
        redirect_valid = 1'b0;
        step();
        total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL boot_redir_pc got=%h want=0", out_pc); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL boot_redir_v got=%b want=1", out_valid); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h20010005 + 32'(i);
        test_reset();
        test_boot_stream();
        test_stall();
        test_wrap();
        test_redirect_stalled();
        test_halt();
        test_jmp();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
